// File: rtl/mem_arbiter.sv
// Round-robin arbiter and sequencer sharing one byte-addressed RAM port between
// instruction fetch (word reads) and load/store (byte/word reads and writes).
module mem_arbiter #(
    parameter int unsigned ADDR_LIMIT = 2048
) (
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_f_req,
    input  logic [15:0] I_f_addr,
    output logic        O_f_ack,
    output logic [15:0] O_f_data,
    output logic        O_f_err,
    input  logic        I_d_req,
    input  logic        I_d_write,
    input  logic [1:0]  I_d_size,
    input  logic [15:0] I_d_addr,
    input  logic [15:0] I_d_data,
    output logic        O_d_ack,
    output logic [15:0] O_d_data,
    output logic        O_d_err,
    output logic        O_ram_enable,
    output logic        O_ram_write,
    output logic [1:0]  O_ram_size,
    output logic [15:0] O_ram_addr,
    output logic [15:0] O_ram_data,
    input  logic [15:0] I_ram_data,
    output logic        O_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_READ, S_DONE} state_t;

    localparam logic [16:0] LIMIT     = 17'(ADDR_LIMIT);
    localparam logic [16:0] LAST_BYTE = 17'(ADDR_LIMIT - 1);

    state_t      state_q, state_d;
    logic        last_q, last_d;
    logic        port_q, port_d;
    logic        err_q, err_d;
    logic [15:0] f_data_q, f_data_d;
    logic [15:0] d_data_q, d_data_d;
    logic        ram_en_q, ram_en_d;
    logic        ram_write_q, ram_write_d;
    logic [1:0]  ram_size_q, ram_size_d;
    logic [15:0] ram_addr_q, ram_addr_d;
    logic [15:0] ram_data_q, ram_data_d;

    logic        gnt_data;
    logic        sel_write;
    logic [1:0]  sel_size;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic        size_bad;
    logic        fault;

    // last_q/port_q: 1 = load/store port, 0 = fetch port
    assign gnt_data  = I_d_req & (~I_f_req | ~last_q);
    assign sel_write = gnt_data & I_d_write;
    assign sel_size  = gnt_data ? I_d_size : 2'd2;
    assign sel_addr  = gnt_data ? I_d_addr : I_f_addr;
    assign sel_wdata = gnt_data ? I_d_data : 16'h0000;
    assign size_bad  = (sel_size != 2'd1) && (sel_size != 2'd2);
    assign fault     = ({1'b0, sel_addr} >= LIMIT) || size_bad ||
                       ((sel_size == 2'd2) && ({1'b0, sel_addr} == LAST_BYTE));

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        port_d      = port_q;
        err_d       = err_q;
        f_data_d    = f_data_q;
        d_data_d    = d_data_q;
        ram_en_d    = 1'b0;
        ram_write_d = 1'b0;
        ram_size_d  = 2'd0;
        ram_addr_d  = 16'h0000;
        ram_data_d  = 16'h0000;
        unique case (state_q)
            S_IDLE: begin
                if (I_f_req || I_d_req) begin
                    port_d = gnt_data;
                    last_d = gnt_data;
                    if (fault) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                        if (gnt_data) d_data_d = 16'h0000;
                        else          f_data_d = 16'h0000;
                    end else begin
                        err_d       = 1'b0;
                        state_d     = S_ISSUE;
                        ram_en_d    = 1'b1;
                        ram_write_d = sel_write;
                        ram_size_d  = sel_size;
                        ram_addr_d  = sel_addr;
                        ram_data_d  = sel_wdata;
                    end
                end
            end
            S_ISSUE: state_d = ram_write_q ? S_DONE : S_READ;
            S_READ: begin
                if (port_q) d_data_d = I_ram_data;
                else        f_data_d = I_ram_data;
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            port_q      <= 1'b0;
            err_q       <= 1'b0;
            f_data_q    <= 16'h0000;
            d_data_q    <= 16'h0000;
            ram_en_q    <= 1'b0;
            ram_write_q <= 1'b0;
            ram_size_q  <= 2'd0;
            ram_addr_q  <= 16'h0000;
            ram_data_q  <= 16'h0000;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            port_q      <= port_d;
            err_q       <= err_d;
            f_data_q    <= f_data_d;
            d_data_q    <= d_data_d;
            ram_en_q    <= ram_en_d;
            ram_write_q <= ram_write_d;
            ram_size_q  <= ram_size_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
        end
    end

    assign O_f_ack      = (state_q == S_DONE) && !port_q;
    assign O_d_ack      = (state_q == S_DONE) && port_q;
    assign O_f_err      = O_f_ack && err_q;
    assign O_d_err      = O_d_ack && err_q;
    assign O_f_data     = f_data_q;
    assign O_d_data     = d_data_q;
    assign O_ram_enable = ram_en_q;
    assign O_ram_write  = ram_write_q;
    assign O_ram_size   = ram_size_q;
    assign O_ram_addr   = ram_addr_q;
    assign O_ram_data   = ram_data_q;
    assign O_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural byte RAM, per-port ack scoreboards and a
// RAM-strobe scoreboard fed by a transaction table plus multi-cycle sequences.
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic        write;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        exp_err;
        logic [15:0] exp_data;
        logic        chk_data;
        int          lat;
    } txn_t;

    typedef struct {
        logic        err;
        logic [15:0] data;
        logic        chk_data;
        int          due;
    } ack_exp_t;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic [15:0] addr;
        logic [15:0] data;
    } ram_exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_req = 1'b0;
    logic [15:0] f_addr = 16'h0;
    logic        f_ack, f_err;
    logic [15:0] f_data;
    logic        d_req = 1'b0, d_write = 1'b0;
    logic [1:0]  d_size = 2'd0;
    logic [15:0] d_addr = 16'h0, d_wdata = 16'h0;
    logic        d_ack, d_err;
    logic [15:0] d_rdata;
    logic        ram_en, ram_wr;
    logic [1:0]  ram_sz;
    logic [15:0] ram_addr, ram_wdata;
    logic [15:0] ram_rdata;
    logic        busy;

    logic [7:0]  mem [0:2047];
    int          cyc = 0;
    int          n_cmp = 0, n_bad = 0;
    ack_exp_t    fq[$], dq[$];
    ram_exp_t    rq[$];
    txn_t        tbl[14];
    txn_t        ft[4], dt[4];

    mem_arbiter #(.ADDR_LIMIT(2048)) dut (
        .I_clk(clk), .I_reset_n(rst_n),
        .I_f_req(f_req), .I_f_addr(f_addr),
        .O_f_ack(f_ack), .O_f_data(f_data), .O_f_err(f_err),
        .I_d_req(d_req), .I_d_write(d_write), .I_d_size(d_size),
        .I_d_addr(d_addr), .I_d_data(d_wdata),
        .O_d_ack(d_ack), .O_d_data(d_rdata), .O_d_err(d_err),
        .O_ram_enable(ram_en), .O_ram_write(ram_wr), .O_ram_size(ram_sz),
        .O_ram_addr(ram_addr), .O_ram_data(ram_wdata),
        .I_ram_data(ram_rdata), .O_busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Little-endian byte RAM with registered read data; preload holds the boot bytes.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rdata <= 16'h0;
            mem[0] <= 8'h00; mem[1] <= 8'h80; mem[2] <= 8'h34; mem[3] <= 8'h12;
            mem[4] <= 8'hCD; mem[5] <= 8'hAB; mem[6] <= 8'h78; mem[7] <= 8'h56;
            mem[2047] <= 8'h5A;
        end else if (ram_en) begin
            if (ram_wr) begin
                mem[ram_addr[10:0]] <= ram_wdata[7:0];
                if (ram_sz == 2'd2) mem[ram_addr[10:0] + 11'd1] <= ram_wdata[15:8];
            end else if (ram_sz == 2'd2) begin
                ram_rdata <= {mem[ram_addr[10:0] + 11'd1], mem[ram_addr[10:0]]};
            end else begin
                ram_rdata <= {8'h00, mem[ram_addr[10:0]]};
            end
        end
    end

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void fail_now(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event without expectation (cycle %0d)", name, cyc);
    endfunction

    always @(negedge clk) begin
        ack_exp_t e;
        ram_exp_t r;
        if (f_ack || d_ack) check("ack_overlap", 32'(f_ack & d_ack), 32'd0);
        if (f_ack) begin
            if (fq.size() == 0) fail_now("f_ack_unexpected");
            else begin
                e = fq.pop_front();
                check("f_err", 32'(f_err), 32'(e.err));
                if (e.chk_data) check("f_data", 32'(f_data), 32'(e.data));
                if (e.due >= 0) check("f_ack_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (d_ack) begin
            if (dq.size() == 0) fail_now("d_ack_unexpected");
            else begin
                e = dq.pop_front();
                check("d_err", 32'(d_err), 32'(e.err));
                if (e.chk_data) check("d_data", 32'(d_rdata), 32'(e.data));
                if (e.due >= 0) check("d_ack_cycle", 32'(cyc), 32'(e.due));
            end
        end
        if (ram_en) begin
            if (rq.size() == 0) fail_now("ram_enable_unexpected");
            else begin
                r = rq.pop_front();
                check("ram_write", 32'(ram_wr), 32'(r.write));
                check("ram_size", 32'(ram_sz), 32'(r.size));
                check("ram_addr", 32'(ram_addr), 32'(r.addr));
                if (r.write) check("ram_data", 32'(ram_wdata), 32'(r.data));
            end
        end else if (rst_n) begin
            check("ram_idle_zero", {13'd0, ram_wr, ram_sz, ram_addr | ram_wdata}, 32'd0);
        end
    end

    task automatic wait_ack(input logic port);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (port ? d_ack : f_ack) got = 1'b1;
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ack_timeout: port %0d got no ack, required ack within 20 cycles", port);
        end
    endtask

    // Call just after a rising edge with the arbiter idle; returns just after
    // the edge following the ack, so back-to-back calls keep req asserted.
    task automatic run_txn(input txn_t t, input bit push_ram);
        ack_exp_t e;
        ram_exp_t r;
        if (t.port) begin
            d_req = 1'b1; d_write = t.write; d_size = t.size;
            d_addr = t.addr; d_wdata = t.wdata;
        end else begin
            f_req = 1'b1; f_addr = t.addr;
        end
        e = '{err: t.exp_err, data: t.exp_data, chk_data: t.chk_data,
              due: (t.lat < 0) ? -1 : cyc + t.lat};
        if (t.port) dq.push_back(e); else fq.push_back(e);
        if (push_ram && !t.exp_err) begin
            r = '{write: t.port & t.write, size: t.port ? t.size : 2'd2,
                  addr: t.addr, data: t.wdata};
            rq.push_back(r);
        end
        wait_ack(t.port);
        @(posedge clk); #1;
        if (t.port) d_req = 1'b0; else f_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        ram_exp_t r;
        //        port wr size addr      wdata     err data      chk lat
        tbl[0]  = '{0, 0, 2'd2, 16'h0000, 16'h0000, 0, 16'h8000, 1, 3};
        tbl[1]  = '{1, 1, 2'd2, 16'h0100, 16'hBEEF, 0, 16'h0000, 0, 2};
        tbl[2]  = '{1, 0, 2'd2, 16'h0100, 16'h0000, 0, 16'hBEEF, 1, 3};
        tbl[3]  = '{1, 0, 2'd1, 16'h0101, 16'h0000, 0, 16'h00BE, 1, 3};
        tbl[4]  = '{1, 0, 2'd2, 16'h0800, 16'h0000, 1, 16'h0000, 1, 1};
        tbl[5]  = '{1, 1, 2'd3, 16'h0010, 16'h5555, 1, 16'h0000, 1, 1};
        tbl[6]  = '{1, 0, 2'd2, 16'h07FF, 16'h0000, 1, 16'h0000, 1, 1};
        tbl[7]  = '{1, 0, 2'd1, 16'h07FF, 16'h0000, 0, 16'h005A, 1, 3};
        tbl[8]  = '{1, 1, 2'd2, 16'h0200, 16'hAAAA, 0, 16'h0000, 0, 2};
        tbl[9]  = '{1, 1, 2'd1, 16'h0200, 16'hFF12, 0, 16'h0000, 0, 2};
        tbl[10] = '{1, 0, 2'd2, 16'h0200, 16'h0000, 0, 16'hAA12, 1, 3};
        tbl[11] = '{0, 0, 2'd2, 16'h07FF, 16'h0000, 1, 16'h0000, 1, 1};
        tbl[12] = '{0, 0, 2'd2, 16'h0002, 16'h0000, 0, 16'h1234, 1, 3};
        tbl[13] = '{1, 1, 2'd0, 16'h0020, 16'h1234, 1, 16'h0000, 0, 1};

        for (int i = 0; i < 4; i++)
            ft[i] = '{0, 0, 2'd2, 16'(2 * i), 16'h0000, 0, 16'h0000, 1, -1};
        ft[0].exp_data = 16'h8000; ft[1].exp_data = 16'h1234;
        ft[2].exp_data = 16'hABCD; ft[3].exp_data = 16'h5678;
        dt[0] = '{1, 1, 2'd2, 16'h0300, 16'h1111, 0, 16'h0000, 0, -1};
        dt[1] = '{1, 0, 2'd2, 16'h0300, 16'h0000, 0, 16'h1111, 1, -1};
        dt[2] = '{1, 1, 2'd1, 16'h0301, 16'h0022, 0, 16'h0000, 0, -1};
        dt[3] = '{1, 0, 2'd2, 16'h0300, 16'h0000, 0, 16'h2211, 1, -1};

        // Reset state
        @(negedge clk);
        check("reset_outputs", {busy, f_ack, f_err, d_ack, d_err, ram_en, ram_wr, ram_sz,
                                23'd0}, 32'd0);
        check("reset_data", {f_data, d_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_txn(tbl[i], 1'b1);

        // Re-reset so fetch wins the first tie, then alternate under contention.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            r = '{write: 1'b0, size: 2'd2, addr: ft[i].addr, data: 16'h0};
            rq.push_back(r);
            r = '{write: dt[i].write, size: dt[i].size, addr: dt[i].addr, data: dt[i].wdata};
            rq.push_back(r);
        end
        fork
            begin
                for (int i = 0; i < 4; i++) run_txn(ft[i], 1'b0);
            end
            begin
                for (int j = 0; j < 4; j++) run_txn(dt[j], 1'b0);
            end
        join

        // Reset during READ of a held load; the request must be re-granted after release.
        @(posedge clk); #1;
        d_req = 1'b1; d_write = 1'b0; d_size = 2'd2; d_addr = 16'h0100; d_wdata = 16'h0;
        r = '{write: 1'b0, size: 2'd2, addr: 16'h0100, data: 16'h0};
        rq.push_back(r);
        repeat (3) @(negedge clk);
        check("busy_in_read", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_outputs", {busy, f_ack, f_err, d_ack, d_err, ram_en, ram_wr, ram_sz,
                                    23'd0}, 32'd0);
        check("rst_async_data", {f_data, d_rdata}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dq.push_back('{err: 1'b0, data: 16'hBEEF, chk_data: 1'b1, due: cyc + 3});
        rq.push_back(r);
        wait_ack(1'b1);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (3) @(negedge clk);

        check("fq_drained", 32'(fq.size()), 32'd0);
        check("dq_drained", 32'(dq.size()), 32'd0);
        check("rq_drained", 32'(rq.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the 16-bit byte-addressed RAM. It shares the single RAM port between the instruction-fetch unit (read-only, word) and the load/store unit (read/write, byte/word). It resolves contention round-robin and drives the RAM enable/write/size/address/data strobes for exactly one cycle per access. It captures registered read data and returns it with a one-cycle acknowledge, and faults out-of-range or malformed requests without touching the RAM.

## Interface
- ADDR_LIMIT, 2048: first illegal byte address; any access with addr >= ADDR_LIMIT faults.
- I_clk  in  1  system clock, all state on rising edge.
- I_reset_n  in  1  reset, asynchronous, active-low; RAM reset at top level is tied to ~I_reset_n.
- I_f_req  in  1  fetch request; held with I_f_addr stable until O_f_ack.
- I_f_addr  in  16  fetch byte address; fetch is always a word read (size 2).
- O_f_ack  out  1  one-cycle pulse: fetch complete.
- O_f_data  out  16  fetch read data; valid in the ack cycle, held until the next fetch ack.
- O_f_err  out  1  qualifies O_f_ack: access faulted.
- I_d_req  in  1  load/store request; held with all I_d_* stable until O_d_ack.
- I_d_write  in  1  1 = store, 0 = load.
- I_d_size  in  2  1 = byte, 2 = word; 0 and 3 are illegal.
- I_d_addr  in  16  load/store byte address.
- I_d_data  in  16  store data; byte store uses [7:0].
- O_d_ack, O_d_data, O_d_err  out  1/16/1  same rules as the fetch port; O_d_data is updated only on load acks.
- O_ram_enable  out  1  RAM enable; high exactly one cycle per legal access.
- O_ram_write, O_ram_size, O_ram_addr, O_ram_data  out  1/2/16/16  RAM strobes; registered, stable for the whole ISSUE cycle, 0 outside it.
- I_ram_data  in  16  RAM read data; valid the cycle after the ISSUE edge.
- O_busy  out  1  high in every state except IDLE.

## Operation
- States: IDLE, ISSUE, READ, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the port not granted last; `last` = data port after reset, so fetch wins the first tie.
  - On grant, latch port, write, size, addr and data. Fetch forces write=0, size=2. Update `last`.
- Fault check in IDLE on the granted request:
  - Conditions: addr >= ADDR_LIMIT; size not 1 or 2; word access with addr = ADDR_LIMIT-1.
  - Fault: go to DONE with err=1, read data 0. The RAM is never enabled. `last` still updates.
- Legal grant: go to ISSUE.
- ISSUE: O_ram_enable=1 with the latched strobes. Store goes to DONE; load goes to READ.
- READ: capture I_ram_data into the granted port's data register, then go to DONE. Byte load: upper byte is 0, as delivered by the RAM.
- DONE: pulse ack (and err if faulted) on the granted port only, then go to IDLE unconditionally.
- A requester may keep req high through the ack cycle to issue a new transaction, presented with new operands from the cycle after ack.
- Requests arriving in any state other than IDLE wait; no request is lost while req is held.
- The arbiter never has more than one access outstanding; the two acks are never high together.

## Timing
- Request first seen high in IDLE at cycle 0.
- Legal store: O_ram_enable in cycle 1; ack in cycle 2.
- Legal load: O_ram_enable in cycle 1; RAM data captured at end of cycle 2; ack with data in cycle 3.
- Faulted request: ack+err in cycle 1.
- Back-to-back sustained throughput: one store per 3 cycles, one load per 4 cycles.
- Async reset:
  - State → IDLE; `last` → data port.
  - All outputs → 0 immediately, including O_ram_enable; O_f_data and O_d_data → 0.
  - An in-flight access is aborted with no ack.
  - A store whose ISSUE edge coincides with reset assertion is not guaranteed.
- First grant is possible in the first cycle after reset release.

## Test plan
- Reset, then fetch at 0x0000 → O_ram_enable in cycle 1 with addr 0x0000, size 2; O_f_ack in cycle 3 with O_f_data = 0x8000 (bootloader bytes 00, 80).
- Store word 0xBEEF at 0x0100, then load word 0x0100 → store ack in cycle 2; load ack 4 cycles after the store's ack cycle with 0xBEEF. Then byte-load 0x0101 → 0x00BE.
- Fetch and load/store request together, both held for 4 transactions each → grants alternate F,D,F,D,...; acks never overlap; all data correct.
- Faults → ack+err in cycle 1, data 0, O_ram_enable never high:
  - load at 0x0800;
  - store with size 3;
  - word load at 0x07FF.
- Assert I_reset_n low during READ of a load → no ack; all outputs 0 at once; after release, the still-held request is re-granted and completes correctly.
- Byte store 0x12 at 0x0200 over an existing word 0xAAAA → a later word load returns 0xAA12.
